// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: operation encoding, FSM states
// and small decode helpers used by the datapath.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } mdu_state_e;

    function automatic logic op_is_mult(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negation, wrapping modulo 2^W.
module mdu_negate #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    assign y = neg ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply and divide: one shift-add or restoring
// shift-subtract step per cycle on operand magnitudes, sign fixed up at the end.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    mdu_state_e         state, state_next;
    mdu_op_e            op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   acc_hi, acc_lo;
    logic [CW-1:0]      cnt;
    logic               neg_q, neg_r;
    logic               accept;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;
    logic [WIDTH-1:0]   iter_hi, iter_lo;
    logic [WIDTH:0]     sum, r_sh;

    wire sgn = op_is_signed(op_q);

    mdu_negate #(.W(WIDTH)) u_abs_a (.neg(sgn && a_q[WIDTH-1]), .x(a_q), .y(mag_a));
    mdu_negate #(.W(WIDTH)) u_abs_b (.neg(sgn && b_q[WIDTH-1]), .x(b_q), .y(mag_b));

    mdu_negate #(.W(2*WIDTH)) u_fix_prod (.neg(neg_q), .x({acc_hi, acc_lo}), .y(prod));
    mdu_negate #(.W(WIDTH))   u_fix_quot (.neg(neg_q), .x(acc_lo), .y(quot));
    mdu_negate #(.W(WIDTH))   u_fix_rem  (.neg(neg_r), .x(acc_hi), .y(rem));

    always_ff @(posedge Clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // A new request is taken only when the unit is not busy.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                accept = start;
                if (start) state_next = PREP;
            end
            PREP: begin
                busy       = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CW'(WIDTH - 1)) state_next = FIX;
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                accept     = start;
                state_next = start ? PREP : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Multiply: {acc_hi,acc_lo} is the product register, multiplier in acc_lo.
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        r_sh    = {acc_hi, acc_lo[WIDTH-1]};
        iter_hi = acc_hi;
        iter_lo = acc_lo;
        if (op_is_mult(op_q)) begin
            iter_hi = sum[WIDTH:1];
            iter_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end else if (r_sh >= {1'b0, opnd}) begin
            iter_hi = WIDTH'(r_sh - {1'b0, opnd});
            iter_lo = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            iter_hi = r_sh[WIDTH-1:0];
            iter_lo = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            op_q     <= MDU_MULT;
            a_q      <= '0;
            b_q      <= '0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= mdu_op_e'(op);
                a_q  <= a;
                b_q  <= b;
            end
            unique case (state)
                PREP: begin
                    opnd   <= op_is_mult(op_q) ? mag_a : mag_b;
                    acc_lo <= op_is_mult(op_q) ? mag_b : mag_a;
                    acc_hi <= '0;
                    cnt    <= '0;
                    neg_q  <= sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_r  <= sgn && a_q[WIDTH-1];
                end
                RUN: begin
                    acc_hi <= iter_hi;
                    acc_lo <= iter_lo;
                    cnt    <= cnt + CW'(1);
                end
                FIX: begin
                    if (op_is_mult(op_q)) begin
                        hi       <= prod[2*WIDTH-1:WIDTH];
                        lo       <= prod[WIDTH-1:0];
                        div_zero <= 1'b0;
                    end else if (b_q == '0) begin
                        hi       <= a_q;
                        lo       <= '1;
                        div_zero <= 1'b1;
                    end else begin
                        hi       <= rem;
                        lo       <= quot;
                        div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit at WIDTH=32, checked
// against a plain-arithmetic reference model through an expected-result queue.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [2*W:0] exp_q[$];

    always #5 Clk = ~Clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .Clk(Clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Returns {div_zero, hi, lo} from signed/unsigned 64-bit arithmetic.
    function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: begin
                p = 64'(sx * sy);
                return {1'b0, p};
            end
            2'd1: begin
                p = {32'd0, x} * {32'd0, y};
                return {1'b0, p};
            end
            2'd2: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                return {1'b0, x % y, x / y};
            end
        endcase
    endfunction

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h1;
            4:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issues one request at the next edge, then scrambles the inputs; with
    // poke set, start is pulsed with other operands while the unit is busy.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
        logic [2*W:0] e;
        int n;
        bit seen;
        op = o; a = x; b = y; start = 1'b1;
        exp_q.push_back(model(o, x, y));
        @(posedge Clk); #1;
        start = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        check("busy_prep", 64'(busy), 64'd1);
        check("done_low", 64'(done), 64'd0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            if (poke && n == 10) begin
                start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge Clk); #1;
            n++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check("latency", 64'(n), 64'(W + 2));
        e = exp_q.pop_front();
        check("lo", 64'(lo), 64'(e[W-1:0]));
        check("hi", 64'(hi), 64'(e[2*W-1:W]));
        check("div_zero", 64'(div_zero), 64'(e[2*W]));
        check("busy_done", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [W-1:0] keep_hi, keep_lo;
        int  n;
        bit  seen;

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(div_zero), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(posedge Clk); #1;

        // Directed cases, issued back to back from DONE.
        do_op(2'd0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0);
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(2'd3, 32'h0000_0064, 32'h0000_0000, 1'b0);
        do_op(2'd1, 32'h0000_0003, 32'h0000_0005, 1'b0);

        // Results hold through IDLE and done is a single-cycle pulse.
        keep_hi = 32'h0; keep_lo = 32'hF;
        repeat (3) @(posedge Clk);
        #1;
        check("hold_hi", 64'(hi), 64'(keep_hi));
        check("hold_lo", 64'(lo), 64'(keep_lo));
        check("idle_done", 64'(done), 64'd0);

        // Start while busy is ignored.
        do_op(2'd2, 32'hFFFF_F123, 32'h0000_0017, 1'b1);
        do_op(2'd0, 32'($urandom), 32'($urandom), 1'b1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge Clk);
                #1;
            end
            do_op(2'($urandom_range(0, 3)), pick_val(), pick_val(), 1'b0);
        end

        // Reset in the middle of RUN discards the operation.
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        op = 2'd1; a = 32'h1234_5678; b = 32'h0000_0101; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        reset = 1'b1;
        @(posedge Clk); #1;
        reset = 1'b0;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_hi", 64'(hi), 64'd0);
        check("mid_rst_lo", 64'(lo), 64'd0);
        check("mid_rst_dz", 64'(div_zero), 64'd0);
        seen = 1'b0;
        for (n = 0; n < 50; n++) begin
            @(posedge Clk); #1;
            if (done || busy) seen = 1'b1;
        end
        check("no_done_after_rst", 64'(seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand width; the legal range is 4 to 64 and even values only.
REQ-002 The module SHALL have these ports, clock and reset first:
- Clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
REQ-003 The module SHALL have these control ports:
- start  input  1  operation request.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-004 The module SHALL have these operand ports:
- a  input  WIDTH  multiplicand or dividend.
- b  input  WIDTH  multiplier or divisor.
REQ-005 The module SHALL have these status ports:
- busy  output  1  operation in progress.
- done  output  1  one-cycle result-valid pulse.
- div_zero  output  1  last division had a zero divisor.
REQ-006 The module SHALL have these result ports:
- hi  output  WIDTH  product upper half, or remainder.
- lo  output  WIDTH  product lower half, or quotient.

Function
REQ-007 The FSM SHALL have the states IDLE, PREP, RUN, FIX and DONE.
REQ-008 The FSM SHALL make these transitions:
- IDLE to PREP when start=1.
- PREP to RUN.
- RUN to FIX after exactly WIDTH iterations.
- FIX to DONE.
- DONE to PREP if start=1, otherwise DONE to IDLE.
REQ-009 op, a and b SHALL be captured only on the edge that accepts start; later changes to these inputs SHALL NOT affect the result.
REQ-010 start SHALL be ignored while busy=1.
REQ-011 busy SHALL be 1 in PREP, RUN and FIX, and 0 in IDLE and DONE.
REQ-012 done SHALL be 1 only in DONE, so it rises exactly WIDTH+2 edges after the accepting edge (34 for WIDTH=32).
REQ-013 PREP SHALL load the operand magnitudes: the absolute value for signed ops and the raw value for unsigned ops.
REQ-014 PREP SHALL record the result sign(s): the product sign, the quotient sign (operand signs differ) and the remainder sign (the dividend sign).
REQ-015 For multiply, RUN SHALL perform one shift-add iteration per cycle on a 2*WIDTH accumulator.
REQ-016 For divide, RUN SHALL perform one restoring shift-subtract iteration per cycle.
REQ-017 In FIX, sign correction SHALL use two's-complement negation modulo 2^WIDTH (2^(2*WIDTH) for the product), and hi/lo SHALL be registered.
REQ-018 hi and lo SHALL hold their values from DONE until the FIX of the next operation.
REQ-019 MULT and MULTU SHALL produce {hi,lo} equal to the exact 2*WIDTH-bit product.
REQ-020 DIV and DIVU SHALL truncate the quotient toward zero; hi SHALL be the remainder and lo the quotient.
REQ-021 For signed division, the remainder sign SHALL equal the dividend sign.
REQ-022 Signed division of the most negative value by -1 SHALL give lo equal to the most negative value, hi=0, and no flag.
REQ-023 Division with b=0 SHALL keep the same latency and SHALL force hi=a (unmodified), lo=all ones and div_zero=1.
REQ-024 div_zero SHALL be updated in FIX of every operation and SHALL be cleared for all multiplies.
REQ-025 Division performed while a division is pending SHALL be impossible; no queueing SHALL be provided.

Reset
REQ-026 When reset=1 at a clock edge, state SHALL become IDLE, and busy, done, div_zero, hi and lo SHALL become 0.
REQ-027 This SHALL apply from any state, including mid-RUN.
REQ-028 reset SHALL take priority over start on the same edge.
REQ-029 No partial result SHALL appear after reset.

Structure
REQ-030 Package mdu_pkg SHALL hold the op enum (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU) and the state enum.
REQ-031 The iteration counter width SHALL be $clog2(WIDTH)+1 and SHALL be local to the module.
REQ-032 One combinational sub-module, mdu_negate (parameter W, conditional two's-complement negate), SHALL be used in PREP and FIX.

Verification
REQ-033 Bench scenarios SHALL use WIDTH=32.
REQ-034 MULT a=7, b=FFFFFFFD -> hi=FFFFFFFF, lo=FFFFFFEB, done exactly 34 edges after start.
REQ-035 MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001, div_zero=0.
REQ-036 DIV a=FFFFFFF9, b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-037 DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
REQ-038 DIVU a=00000064, b=0 -> hi=00000064, lo=FFFFFFFF, div_zero=1.
REQ-039 This scenario SHALL use back-to-back start in DONE:
- A subsequent MULTU 3x5 SHALL give lo=0000000F and div_zero=0.
REQ-040 This scenario SHALL exercise start while busy and reset mid-RUN:
- Pulse start with different operands mid-RUN; the result SHALL be unaffected.
- Then assert reset at RUN iteration 10; on the next cycle busy=0, hi=lo=0, and no done SHALL follow.
